// File: rtl/sort_pkg.sv
// Shared defaults and FSM state type for the bubble sort sequencer.
package sort_pkg;

  localparam int DEF_N_ELEM = 8;
  localparam int DEF_DATA_W = 32;
  localparam int IDX_W      = $clog2(DEF_N_ELEM);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    PASS_END,
    FIN
  } state_t;

endpackage

// File: rtl/bubble_sort_sequencer_if.sv
// Host-side bus of the bubble sort sequencer: element load/readback, start, status.
interface bubble_sort_sequencer_if #(
  parameter int N_ELEM = sort_pkg::DEF_N_ELEM,
  parameter int DATA_W = sort_pkg::DEF_DATA_W
);
  localparam int AW = $clog2(N_ELEM);

  logic              start;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic [4:0]        pass_cnt;
  logic [15:0]       swap_cnt;
  logic              wr_err;

  modport master (
    output start, wr_en, wr_addr, wr_data, rd_addr,
    input  rd_data, busy, done, pass_cnt, swap_cnt, wr_err
  );

  modport slave (
    input  start, wr_en, wr_addr, wr_data, rd_addr,
    output rd_data, busy, done, pass_cnt, swap_cnt, wr_err
  );
endinterface

// File: rtl/sort_cmp_swap.sv
// Combinational compare-and-swap: orders an unsigned pair; equal values never swap.
module sort_cmp_swap #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi,
  output logic              swap
);
  assign swap = (a > b);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;
endmodule

// File: rtl/bubble_sort_sequencer.sv
// In-place bubble sort over a flop register file, one adjacent compare per clock,
// with early exit on a pass that performs no swap.
module bubble_sort_sequencer
  import sort_pkg::*;
#(
  parameter int N_ELEM = DEF_N_ELEM,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic                    ACLK,
  input logic                    ARESET,
  bubble_sort_sequencer_if.slave bus
);
  localparam int AW = $clog2(N_ELEM);
  typedef logic [AW-1:0] idx_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] arr_q [N_ELEM];
  logic [DATA_W-1:0] arr_d [N_ELEM];
  idx_t              j_q, j_d, last_q, last_d;
  logic              swapped_q, swapped_d;
  logic              done_q, done_d;
  logic              wr_err_q, wr_err_d;
  logic [4:0]        pass_cnt_q, pass_cnt_d;
  logic [15:0]       swap_cnt_q, swap_cnt_d;

  idx_t              j_p1;
  logic [DATA_W-1:0] cmp_lo, cmp_hi;
  logic              cmp_swap;

  assign j_p1 = j_q + idx_t'(1);

  sort_cmp_swap #(.DATA_W(DATA_W)) u_cmp (
    .a    (arr_q[j_q]),
    .b    (arr_q[j_p1]),
    .lo   (cmp_lo),
    .hi   (cmp_hi),
    .swap (cmp_swap)
  );

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    arr_d      = arr_q;
    j_d        = j_q;
    last_d     = last_q;
    swapped_d  = swapped_q;
    done_d     = done_q;
    pass_cnt_d = pass_cnt_q;
    swap_cnt_d = swap_cnt_q;
    wr_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Write is applied before the start test so the first compare sees it.
        if (bus.wr_en) begin
          arr_d[bus.wr_addr] = bus.wr_data;
          done_d             = 1'b0;
        end
        if (bus.start) begin
          state_d    = SCAN;
          pass_cnt_d = '0;
          swap_cnt_d = '0;
          done_d     = 1'b0;
          j_d        = '0;
          last_d     = idx_t'(N_ELEM - 1);
          swapped_d  = 1'b0;
        end
      end
      SCAN: begin
        if (cmp_swap) begin
          arr_d[j_q]  = cmp_lo;
          arr_d[j_p1] = cmp_hi;
          swapped_d   = 1'b1;
          if (swap_cnt_q != 16'hFFFF) swap_cnt_d = swap_cnt_q + 16'd1;
        end
        if (j_p1 == last_q) state_d = PASS_END;
        else                j_d     = j_p1;
      end
      PASS_END: begin
        pass_cnt_d = pass_cnt_q + 5'd1;
        if (!swapped_q || last_q == idx_t'(1)) begin
          state_d = FIN;
        end else begin
          last_d    = last_q - idx_t'(1);
          j_d       = '0;
          swapped_d = 1'b0;
          state_d   = SCAN;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && bus.wr_en) wr_err_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race readers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= IDLE;
      j_q        <= '0;
      last_q     <= '0;
      swapped_q  <= 1'b0;
      done_q     <= 1'b0;
      wr_err_q   <= 1'b0;
      pass_cnt_q <= '0;
      swap_cnt_q <= '0;
      // NOTE: the array is plain flops, so clearing it on reset is legal and keeps it out of RAM.
      for (int i = 0; i < N_ELEM; i++) arr_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      j_q        <= j_d;
      last_q     <= last_d;
      swapped_q  <= swapped_d;
      done_q     <= done_d;
      wr_err_q   <= wr_err_d;
      pass_cnt_q <= pass_cnt_d;
      swap_cnt_q <= swap_cnt_d;
      arr_q      <= arr_d;
    end
  end

  assign bus.rd_data  = arr_q[bus.rd_addr];
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.pass_cnt = pass_cnt_q;
  assign bus.swap_cnt = swap_cnt_q;
  assign bus.wr_err   = wr_err_q;

endmodule

// File: tb/tb_bubble_sort_sequencer.sv
// Self-checking bench: directed and random arrays against an inversion-count sort model.
module tb_bubble_sort_sequencer;
  localparam int N = 8;
  typedef logic [31:0] arr_t [N];

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  bubble_sort_sequencer_if #(.N_ELEM(N), .DATA_W(32)) bus ();

  bubble_sort_sequencer #(.N_ELEM(N), .DATA_W(32)) dut (
    .ACLK   (clk),
    .ARESET (rst),
    .bus    (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bubble sort with early exit: swaps = strict inversions; passes = 1 + max count of
  // strictly larger elements ahead of any element, capped at N-1; pass i scans N-i pairs.
  task automatic model(input arr_t a, output arr_t s, output int passes, output int swaps,
                       output int busy_cyc);
    logic [31:0] q[$];
    int kmax = 0;
    swaps = 0;
    for (int j = 0; j < N; j++) begin
      int k = 0;
      for (int i = 0; i < j; i++) if (a[i] > a[j]) k++;
      swaps += k;
      if (k > kmax) kmax = k;
    end
    passes = (kmax + 1 < N - 1) ? kmax + 1 : N - 1;
    busy_cyc = passes + 1;
    for (int p = 1; p <= passes; p++) busy_cyc += N - p;
    foreach (a[i]) q.push_back(a[i]);
    q.sort();
    foreach (s[i]) s[i] = q[i];
  endtask

  task automatic load(input arr_t a);
    for (int i = 0; i < N; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 3'(i);
      bus.wr_data = a[i];
      step();
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic check_array(input string tag, input arr_t e);
    for (int i = 0; i < N; i++) begin
      bus.rd_addr = 3'(i);
      step();
      check($sformatf("%s rd[%0d]", tag, i), 64'(bus.rd_data), 64'(e[i]));
    end
  endtask

  task automatic wait_idle(input int n0, output int n);
    n = n0;
    while (bus.busy === 1'b1 && n < 1000) begin
      n++;
      step();
    end
  endtask

  task automatic check_result(input string tag, input int n, input arr_t s, input int passes,
                              input int swaps, input int busy_cyc);
    check({tag, " busy_cycles"}, 64'(n), 64'(busy_cyc));
    check({tag, " done"}, 64'(bus.done), 64'd1);
    check({tag, " pass_cnt"}, 64'(bus.pass_cnt), 64'(passes));
    check({tag, " swap_cnt"}, 64'(bus.swap_cnt), 64'(swaps));
    check_array(tag, s);
  endtask

  task automatic sort_and_check(input string tag, input arr_t a);
    arr_t s;
    int passes, swaps, busy_cyc, n;
    model(a, s, passes, swaps, busy_cyc);
    load(a);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check({tag, " busy_after_start"}, 64'(bus.busy), 64'd1);
    wait_idle(0, n);
    check_result(tag, n, s, passes, swaps, busy_cyc);
  endtask

  initial begin
    arr_t asc, desc, dups, zeros, a, s;
    int passes, swaps, busy_cyc, n;

    for (int i = 0; i < N; i++) begin
      asc[i]   = 32'(i + 1);
      desc[i]  = 32'(N - i);
      zeros[i] = '0;
    end
    dups = '{32'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd3, 32'd3, 32'd1, 32'd0};

    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_addr = '0;
    step();
    step();
    rst = 1'b0;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset pass_cnt", 64'(bus.pass_cnt), 64'd0);
    check("reset swap_cnt", 64'(bus.swap_cnt), 64'd0);
    check("reset wr_err", 64'(bus.wr_err), 64'd0);
    check_array("reset", zeros);

    sort_and_check("ascending", asc);
    sort_and_check("descending", desc);
    sort_and_check("duplicates", dups);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++)
        a[i] = (r % 2 == 0) ? $urandom : 32'($urandom_range(0, 4));
      sort_and_check($sformatf("random%0d", r), a);
    end

    // Done is sticky through idle cycles and cleared by an accepted write.
    step();
    check("done sticky", 64'(bus.done), 64'd1);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'd0;
    bus.wr_data = 32'd7;
    step();
    bus.wr_en = 1'b0;
    check("done cleared by write", 64'(bus.done), 64'd0);
    check("idle write no wr_err", 64'(bus.wr_err), 64'd0);

    // Write and restart attempt while busy: rejected, flagged once, sort unaffected.
    model(desc, s, passes, swaps, busy_cyc);
    load(desc);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n = 0;
    repeat (3) begin
      n++;
      step();
    end
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'd0;
    bus.wr_data = 32'd99;
    bus.start   = 1'b1;
    n++;
    step();
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
    check("busy write wr_err pulse", 64'(bus.wr_err), 64'd1);
    n++;
    step();
    check("busy write wr_err clears", 64'(bus.wr_err), 64'd0);
    wait_idle(n, n);
    check_result("busy_write", n, s, passes, swaps, busy_cyc);

    // Write and start in the same idle cycle: the sort sees the new value.
    a = desc;
    a[3] = 32'd0;
    model(a, s, passes, swaps, busy_cyc);
    load(desc);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'd3;
    bus.wr_data = 32'd0;
    bus.start   = 1'b1;
    step();
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
    wait_idle(0, n);
    check_result("write_with_start", n, s, passes, swaps, busy_cyc);
    check("write_with_start expect", 64'(s[5]), 64'd6);

    // Reset mid-sort, with start and write held during the reset cycle.
    load(desc);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (10) step();
    check("pre-reset busy", 64'(bus.busy), 64'd1);
    rst         = 1'b1;
    bus.start   = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'd2;
    bus.wr_data = 32'd55;
    step();
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    check("midreset busy", 64'(bus.busy), 64'd0);
    check("midreset done", 64'(bus.done), 64'd0);
    check("midreset pass_cnt", 64'(bus.pass_cnt), 64'd0);
    check("midreset swap_cnt", 64'(bus.swap_cnt), 64'd0);
    check("midreset wr_err", 64'(bus.wr_err), 64'd0);
    check_array("midreset", zeros);
    check("midreset stays idle", 64'(bus.busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
